// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         BCD_W   = 4;

endpackage

// File: rtl/freq_meter_if.sv
// Measurement bus: measured signal and enable in, latched BCD result out.
interface freq_meter_if
    import freq_meter_pkg::*;
#(
    parameter int DIGITS = 4
) ();

    logic                      sig_in;
    logic                      enable;
    logic [BCD_W*DIGITS-1:0]   bcd_out;
    logic                      valid;
    logic                      overflow;

    modport master (
        output sig_in,
        output enable,
        input  bcd_out,
        input  valid,
        input  overflow
    );

    modport slave (
        input  sig_in,
        input  enable,
        output bcd_out,
        output valid,
        output overflow
    );

endinterface

// File: rtl/bcd_digit.sv
// One decimal digit of the accumulator; wraps 9->0 and ripples carry to the next digit.
module bcd_digit
    import freq_meter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             cin,
    output logic [BCD_W-1:0] digit,
    output logic             cout
);

    assign cout = cin && (digit == BCD_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit <= '0;
        end else if (clear) begin
            digit <= '0;
        end else if (cin) begin
            digit <= (digit == BCD_MAX) ? '0 : digit + 1'b1;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts sig_in rising edges over GATE_CYCLES clocks,
// reports the count as packed BCD with a one-cycle valid strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int DIGITS      = 4
) (
    input  logic        clk,
    input  logic        reset,
    freq_meter_if.slave bus
);

    localparam int               CNT_W     = $clog2(GATE_CYCLES);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

    state_t                  state;
    logic [CNT_W-1:0]        gate_cnt;
    logic                    ovf_flag;
    logic                    sig_p0, sig_p1, sig_p2;
    logic                    rise;
    logic                    all_nines;
    logic                    inc;
    logic                    clear;
    logic [DIGITS:0]         carry;
    logic [BCD_W*DIGITS-1:0] acc;

    // Input stage: two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_p0 <= 1'b0;
            sig_p1 <= 1'b0;
            sig_p2 <= 1'b0;
        end else begin
            sig_p0 <= bus.sig_in;
            sig_p1 <= sig_p0;
            sig_p2 <= sig_p1;
        end
    end

    assign rise = sig_p1 && !sig_p2;

    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[i*BCD_W +: BCD_W] != BCD_MAX) all_nines = 1'b0;
        end
    end

    // Saturate at full scale: an edge on all 9s is recorded as overflow, not counted
    assign inc      = (state == COUNT) && rise && !all_nines;
    assign clear    = (state != COUNT);
    assign carry[0] = inc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .cin   (carry[g]),
            .digit (acc[g*BCD_W +: BCD_W]),
            .cout  (carry[g+1])
        );
    end

    wire carry_unused = carry[DIGITS];

    // Control stage: gate window sequencing and registered result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            gate_cnt     <= '0;
            ovf_flag     <= 1'b0;
            bus.bcd_out  <= '0;
            bus.valid    <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    ovf_flag <= 1'b0;
                    if (bus.enable) state <= COUNT;
                end
                COUNT: begin
                    if (rise && all_nines) ovf_flag <= 1'b1;
                    if (gate_cnt == GATE_LAST) begin
                        gate_cnt <= '0;
                        state    <= LATCH;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    bus.bcd_out  <= acc;
                    bus.overflow <= ovf_flag;
                    bus.valid    <= 1'b1;
                    ovf_flag     <= 1'b0;
                    gate_cnt     <= '0;
                    state        <= bus.enable ? COUNT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 4-digit and a 2-digit meter run side by side.
module tb_freq_meter;

    localparam int GATE = 1000;

    logic clk = 1'b0;
    logic reset;

    int n_cmp = 0;
    int n_err = 0;
    int ncyc  = 0;
    int per4  = 10;
    int per2  = 4;
    int t_prev;
    int t_now;
    int nval;

    freq_meter_if #(.DIGITS(4)) if4 ();
    freq_meter_if #(.DIGITS(2)) if2 ();

    freq_meter #(.GATE_CYCLES(GATE), .DIGITS(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    freq_meter #(.GATE_CYCLES(GATE), .DIGITS(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    always #5 clk = ~clk;

    // Free-running measured signals; period changes take effect at the next half-period
    initial begin
        if4.sig_in = 1'b0;
        forever begin
            repeat (per4 / 2) @(negedge clk);
            if4.sig_in = 1'b1;
            repeat (per4 - per4 / 2) @(negedge clk);
            if4.sig_in = 1'b0;
        end
    end

    initial begin
        if2.sig_in = 1'b0;
        forever begin
            repeat (per2 / 2) @(negedge clk);
            if2.sig_in = 1'b1;
            repeat (per2 - per2 / 2) @(negedge clk);
            if2.sig_in = 1'b0;
        end
    end

    function automatic int bcd2int(input logic [15:0] b);
        int v;
        v = 0;
        for (int i = 3; i >= 0; i--) begin
            if (b[i*4 +: 4] > 4'd9) return -100;
            v = v * 10 + int'(b[i*4 +: 4]);
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [15:0] bcd, input int exp);
        int v;
        bit ok;
        v  = bcd2int(bcd);
        ok = (v >= exp - 1) && (v <= exp + 1);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0d +/-1", tag, bcd, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        ncyc++;
    endtask

    task automatic wait_valid(input string tag, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (if4.valid === 1'b1) begin
                at = ncyc;
                break;
            end
        end
        n_cmp++;
        assert (at >= 0) else begin
            n_err++;
            $error("FAIL %s: observed no valid, expected valid within %0d cycles", tag, limit);
        end
    endtask

    initial begin
        reset      = 1'b0;
        if4.enable = 1'b1;
        if2.enable = 1'b1;

        // Reset held with enable high and inputs toggling: outputs stay clear
        for (int k = 0; k < 11; k++) begin
            repeat (100) step();
            check("rst_hold4", 32'({if4.valid, if4.overflow, if4.bcd_out}), 32'd0);
            check("rst_hold2", 32'({if2.valid, if2.overflow, if2.bcd_out}), 32'd0);
        end

        // First window after release: period 10 on the 4-digit meter, period 4 saturates the 2-digit one
        reset  = 1'b1;
        t_prev = ncyc;
        wait_valid("w1_valid", 1100, t_now);
        check("w1_latency", 32'(t_now - t_prev), 32'd1002);
        check_near("w1_cnt4", if4.bcd_out, 100);
        check("w1_ovf4", 32'(if4.overflow), 32'd0);
        check("w1_bcd2", 32'(if2.bcd_out), 32'h99);
        check("w1_ovf2", 32'(if2.overflow), 32'd1);
        step();
        check("w1_pulse", 32'(if4.valid), 32'd0);

        t_prev = t_now;
        wait_valid("w2_valid", 1100, t_now);
        check("w2_gap", 32'(t_now - t_prev), 32'd1001);
        check_near("w2_cnt4", if4.bcd_out, 100);
        check("w2_bcd2", 32'(if2.bcd_out), 32'h99);
        step();
        check("w2_pulse", 32'(if4.valid), 32'd0);

        // Switch rates; the next window is mixed, the one after is clean
        per4   = 4;
        per2   = 20;
        t_prev = t_now;
        wait_valid("w3_valid", 1100, t_now);
        check("w3_gap", 32'(t_now - t_prev), 32'd1001);
        t_prev = t_now;
        wait_valid("w4_valid", 1100, t_now);
        check("w4_gap", 32'(t_now - t_prev), 32'd1001);
        check_near("w4_cnt4", if4.bcd_out, 250);
        check("w4_ovf4", 32'(if4.overflow), 32'd0);
        check_near("w4_cnt2", {8'h00, if2.bcd_out}, 50);
        check("w4_ovf2", 32'(if2.overflow), 32'd0);

        // Reset pulse 300 cycles into a window: asynchronous clear, window discarded
        per4 = 10;
        repeat (300) step();
        #2 reset = 1'b0;
        #1;
        check("async_clr4", 32'({if4.valid, if4.overflow, if4.bcd_out}), 32'd0);
        check("async_clr2", 32'({if2.valid, if2.overflow, if2.bcd_out}), 32'd0);
        repeat (5) step();
        reset  = 1'b1;
        t_prev = ncyc;
        wait_valid("post_rst_valid", 1100, t_now);
        check("post_rst_latency", 32'(t_now - t_prev), 32'd1002);
        check_near("post_rst_cnt4", if4.bcd_out, 100);
        check_near("post_rst_cnt2", {8'h00, if2.bcd_out}, 50);
        step();
        check("post_rst_pulse", 32'(if4.valid), 32'd0);

        // Enable dropped mid-window: that window still reports, then the meter idles
        t_prev = t_now;
        repeat (500) step();
        if4.enable = 1'b0;
        if2.enable = 1'b0;
        wait_valid("en_drop_valid", 1100, t_now);
        check("en_drop_gap", 32'(t_now - t_prev), 32'd1001);
        check_near("en_drop_cnt4", if4.bcd_out, 100);
        nval = 0;
        repeat (2100) begin
            step();
            if (if4.valid === 1'b1) nval++;
        end
        check("idle_no_valid", 32'(nval), 32'd0);

        // Re-enable from IDLE
        if4.enable = 1'b1;
        if2.enable = 1'b1;
        t_prev = ncyc;
        wait_valid("reen_valid", 1100, t_now);
        check("reen_latency", 32'(t_now - t_prev), 32'd1002);
        check_near("reen_cnt4", if4.bcd_out, 100);
        check("reen_ovf4", 32'(if4.overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
